// File: rtl/dram_read_scatter_pkg.sv
// ============================================================================
// Module   : dram_read_scatter_pkg
// Desc     : Shared TileAccumUnit configuration defaults for the DRAM read
//            scatter block (address width, data width, lanes, line size).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_read_scatter_pkg;

  // TauCfg defaults; the line size must be a power of two
  localparam int TAU_GBW   = 32;  // global word-address width
  localparam int TAU_DBW   = 16;  // data word width
  localparam int TAU_VSIZE = 32;  // lanes per vector
  localparam int TAU_CSIZE = 32;  // words per DRAM line

endpackage

`default_nettype wire

// File: rtl/dram_read_scatter_if.sv
// ============================================================================
// Module   : dram_read_scatter_if
// Desc     : Handshake bundle for dram_read_scatter: address-vector input,
//            DRAM read request / read data, and assembled-vector output.
//            The slave modport is the scatter block's view; master is the
//            surrounding environment's view.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dram_read_scatter_if
  import dram_read_scatter_pkg::*;
#(
  parameter int GBW   = TAU_GBW,
  parameter int DBW   = TAU_DBW,
  parameter int VSIZE = TAU_VSIZE,
  parameter int CSIZE = TAU_CSIZE
) ();

  // address vector from the read-address generator
  logic                          addrval_rdy;
  logic                          addrval_ack;
  logic [VSIZE-1:0][GBW-1:0]     i_address;
  logic [VSIZE-1:0]              i_valid;

  // DRAM line read request
  logic                          dramra_rdy;
  logic                          dramra_ack;
  logic [GBW-1:0]                o_dramra;

  // DRAM line read data
  logic                          dramrd_rdy;
  logic                          dramrd_ack;
  logic [CSIZE-1:0][DBW-1:0]     i_dramrd;

  // assembled vector to the ALU input buffer
  logic                          dat_rdy;
  logic                          dat_ack;
  logic [VSIZE-1:0][DBW-1:0]     o_dat;
  logic [VSIZE-1:0]              o_valid;

  modport slave (
    input  addrval_rdy, i_address, i_valid,
    input  dramra_ack,
    input  dramrd_rdy, i_dramrd,
    input  dat_ack,
    output addrval_ack,
    output dramra_rdy, o_dramra,
    output dramrd_ack,
    output dat_rdy, o_dat, o_valid
  );

  modport master (
    output addrval_rdy, i_address, i_valid,
    output dramra_ack,
    output dramrd_rdy, i_dramrd,
    output dat_ack,
    input  addrval_ack,
    input  dramra_rdy, o_dramra,
    input  dramrd_ack,
    input  dat_rdy, o_dat, o_valid
  );

endinterface

`default_nettype wire

// File: rtl/dram_read_scatter_line_match.sv
// ============================================================================
// Module   : dram_read_scatter_line_match
// Desc     : Combinational lane/line matcher. Flags pending lanes that fall in
//            the current line, gives each lane's word offset within its line,
//            and returns the line of the lowest pending lane left over after
//            the matched lanes are removed (the next line to request).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_read_scatter_line_match
  import dram_read_scatter_pkg::*;
#(
  parameter  int GBW   = TAU_GBW,
  parameter  int VSIZE = TAU_VSIZE,
  parameter  int CSIZE = TAU_CSIZE,
  localparam int CBW   = $clog2(CSIZE)
) (
  input  logic [VSIZE-1:0][GBW-1:0] address,
  input  logic [VSIZE-1:0]          pending,
  input  logic [GBW-1:0]            cur_line,
  input  logic                      match_en,
  output logic [GBW-1:0]            next_line,
  output logic [VSIZE-1:0]          match,
  output logic [VSIZE-1:0][CBW-1:0] offset
);

  // clears the word-offset bits to form a line-aligned address
  localparam logic [GBW-1:0] LINE_MASK = ~(GBW'(CSIZE - 1));

  logic [VSIZE-1:0] remaining;

  // per-lane line compare and in-line word offset
  always_comb begin
    match  = '0;
    offset = '0;
    for (int i = 0; i < VSIZE; i++) begin
      offset[i] = address[i][CBW-1:0];
      match[i]  = match_en && pending[i] && ((address[i] & LINE_MASK) == cur_line);
    end
  end

  assign remaining = pending & ~match;

  // priority select: scanning downwards leaves the lowest remaining lane's line
  always_comb begin
    next_line = '0;
    for (int i = VSIZE - 1; i >= 0; i--) begin
      if (remaining[i]) begin
        next_line = address[i] & LINE_MASK;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dram_read_scatter.sv
// ============================================================================
// Module   : dram_read_scatter
// Desc     : Read-side scatter for the TileAccumUnit. Accepts a vector of lane
//            word addresses plus a lane-valid mask, issues one DRAM line read
//            per distinct line (lowest lane first, one outstanding), scatters
//            the returned words into their lanes and presents the vector.
// Options  : DRAM_READ_SCATTER_ZERO_FILL_EN - when defined, lanes that are
//            invalid in an accepted vector are cleared to zero; otherwise they
//            keep their previous data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_read_scatter
  import dram_read_scatter_pkg::*;
#(
  parameter int GBW   = TAU_GBW,
  parameter int DBW   = TAU_DBW,
  parameter int VSIZE = TAU_VSIZE,
  parameter int CSIZE = TAU_CSIZE
) (
  input  logic               i_clk,
  input  logic               i_rst,   // asynchronous, active low
  dram_read_scatter_if.slave bus
);

  localparam int CBW = $clog2(CSIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_next;

  logic [VSIZE-1:0][GBW-1:0] lane_addr;
  logic [VSIZE-1:0]          valid_mask;
  logic [VSIZE-1:0]          pending;
  logic [GBW-1:0]            req_line;
  logic [VSIZE-1:0][DBW-1:0] dat_vec;

  logic [VSIZE-1:0][GBW-1:0] match_addr;
  logic [VSIZE-1:0]          match_pend;
  logic [VSIZE-1:0]          match;
  logic [VSIZE-1:0][CBW-1:0] offset;
  logic [GBW-1:0]            next_line;
  logic                      accept;
  logic                      data_take;
  logic                      lanes_left;

  // While idle the matcher looks straight at the incoming vector so the first
  // request line is ready to register on the accept edge; afterwards it works
  // on the latched addresses and the shrinking pending mask.
  assign match_addr = (state == IDLE) ? bus.i_address : lane_addr;
  assign match_pend = (state == IDLE) ? bus.i_valid   : pending;

  dram_read_scatter_line_match #(
    .GBW   (GBW),
    .VSIZE (VSIZE),
    .CSIZE (CSIZE)
  ) u_line_match (
    .address   (match_addr),
    .pending   (match_pend),
    .cur_line  (req_line),
    .match_en  (state == WAIT),
    .next_line (next_line),
    .match     (match),
    .offset    (offset)
  );

  assign accept     = bus.addrval_rdy && bus.addrval_ack;
  assign data_take  = (state == WAIT) && bus.dramrd_rdy;
  assign lanes_left = |(pending & ~match);

  // state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state and handshake acks/rdys, each decoded from the state alone
  always_comb begin
    state_next      = state;
    bus.addrval_ack = 1'b0;
    bus.dramra_rdy  = 1'b0;
    bus.dramrd_ack  = 1'b0;
    bus.dat_rdy     = 1'b0;
    case (state)
      IDLE: begin
        bus.addrval_ack = 1'b1;
        if (bus.addrval_rdy) begin
          state_next = (|bus.i_valid) ? REQ : OUT;
        end
      end
      REQ: begin
        bus.dramra_rdy = 1'b1;
        if (bus.dramra_ack) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        bus.dramrd_ack = 1'b1;
        if (bus.dramrd_rdy) begin
          state_next = lanes_left ? REQ : OUT;
        end
      end
      OUT: begin
        bus.dat_rdy = 1'b1;
        if (bus.dat_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // vector bookkeeping: latch on accept, retire matched lanes on each line
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lane_addr  <= '0;
      valid_mask <= '0;
      pending    <= '0;
      req_line   <= '0;
    end else if (accept) begin
      lane_addr  <= bus.i_address;
      valid_mask <= bus.i_valid;
      pending    <= bus.i_valid;
      req_line   <= next_line;
    end else if (data_take) begin
      pending <= pending & ~match;
      if (lanes_left) begin
        req_line <= next_line;
      end
    end
  end

  // lane data: scatter returned line words into every lane on that line
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dat_vec <= '0;
    end else begin
`ifdef DRAM_READ_SCATTER_ZERO_FILL_EN
      if (accept) begin
        for (int i = 0; i < VSIZE; i++) begin
          if (!bus.i_valid[i]) begin
            dat_vec[i] <= '0;
          end
        end
      end
`endif
      if (data_take) begin
        for (int i = 0; i < VSIZE; i++) begin
          if (match[i]) begin
            dat_vec[i] <= bus.i_dramrd[offset[i]];
          end
        end
      end
    end
  end

  assign bus.o_dramra = req_line;
  assign bus.o_dat    = dat_vec;
  assign bus.o_valid  = valid_mask;

endmodule

`default_nettype wire

// File: tb/tb_dram_read_scatter.sv
// ============================================================================
// Module   : tb_dram_read_scatter
// Desc     : Self-checking bench for dram_read_scatter (VSIZE=4, CSIZE=8,
//            GBW=16, DBW=16). A queue-based model derives the expected line
//            requests and lane data from each accepted vector; directed
//            vectors pin the model with hand-computed literals, then random
//            vectors run against it with random DRAM/consumer stalls.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dram_read_scatter;

  localparam int GBW   = 16;
  localparam int DBW   = 16;
  localparam int VSIZE = 4;
  localparam int CSIZE = 8;
  localparam logic [15:0] LMASK = 16'hFFF8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dram_read_scatter_if #(.GBW(GBW), .DBW(DBW), .VSIZE(VSIZE), .CSIZE(CSIZE)) bus ();

  dram_read_scatter #(.GBW(GBW), .DBW(DBW), .VSIZE(VSIZE), .CSIZE(CSIZE)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // environment configuration
  bit hash_mode    = 0;
  bit rand_env     = 0;
  int ra_stall_cfg = 0;
  int rd_delay_cfg = 0;
  int dat_stall_cfg = 0;

  // DRAM contents as a function of word address
  function automatic logic [15:0] word_of(input logic [15:0] a);
    if (hash_mode) return (a * 16'h9E37) ^ 16'h5A5A;
    else           return a + 16'h00F0;
  endfunction

  // model state
  logic [3:0][15:0] exp_dat   = '0;
  logic [3:0]       exp_valid = '0;
  logic [15:0]      reqq[$];
  logic [15:0]      req_log[$];
  logic [15:0]      last_req;
  logic [63:0]      last_dat;
  logic [3:0]       last_valid;
  bit busy, vec_done, acc_evt, hs_ra, hs_rd, lat_seen, zero_wait;
  int cyc, acc_cyc, last_lat, exp_n;

  // compare process: every negedge, check outputs against the model
  always @(negedge clk) begin : chk
    logic [15:0] ln;
    bit seen;
    if (!rst_n) begin
      hs_ra = 0;
      hs_rd = 0;
    end else begin
      cyc++;
      check("addrval_ack", 64'(bus.addrval_ack), 64'(!busy));
      if (!busy) begin
        check("idle_dramra_rdy", 64'(bus.dramra_rdy), 64'd0);
        check("idle_dat_rdy", 64'(bus.dat_rdy), 64'd0);
      end
      hs_ra = 0;
      if (bus.dramra_rdy && busy) begin
        check("o_dramra", 64'(bus.o_dramra), 64'(reqq.size() > 0 ? reqq[0] : 16'hDEAD));
        if (bus.dramra_ack) begin
          hs_ra    = 1;
          last_req = bus.o_dramra;
          req_log.push_back(bus.o_dramra);
          if (reqq.size() > 0) void'(reqq.pop_front());
        end
      end
      hs_rd = bus.dramrd_rdy && bus.dramrd_ack;
      if (bus.dat_rdy && busy) begin
        if (!lat_seen) begin
          lat_seen = 1;
          last_lat = cyc - acc_cyc;
          check("reqs_left_at_out", 64'(reqq.size()), 64'd0);
          if (zero_wait) check("latency", 64'(last_lat), 64'(exp_n == 0 ? 1 : 1 + 2 * exp_n));
        end
        check("o_dat", bus.o_dat, exp_dat);
        check("o_valid", 64'(bus.o_valid), 64'(exp_valid));
        if (bus.dat_ack) begin
          busy       = 0;
          vec_done   = 1;
          last_dat   = bus.o_dat;
          last_valid = bus.o_valid;
        end
      end
      if (bus.addrval_rdy && bus.addrval_ack) begin
        reqq.delete();
        for (int i = 0; i < VSIZE; i++) begin
          if (bus.i_valid[i]) begin
            ln   = bus.i_address[i] & LMASK;
            seen = 0;
            foreach (reqq[j]) if (reqq[j] == ln) seen = 1;
            if (!seen) reqq.push_back(ln);
            exp_dat[i] = word_of(bus.i_address[i]);
          end else begin
`ifdef DRAM_READ_SCATTER_ZERO_FILL_EN
            exp_dat[i] = '0;
`endif
          end
        end
        exp_valid = bus.i_valid;
        exp_n     = reqq.size();
        zero_wait = !rand_env && ra_stall_cfg == 0 && rd_delay_cfg == 0;
        busy      = 1;
        lat_seen  = 0;
        acc_cyc   = cyc;
        acc_evt   = 1;
      end
    end
  end

  // DRAM and consumer responders
  initial begin : env
    int ra_cnt, rd_cnt, dat_cnt;
    bit have_req, prev_ra, prev_dat;
    logic [15:0] rline;
    ra_cnt = 0; rd_cnt = 0; dat_cnt = 0;
    have_req = 0; prev_ra = 0; prev_dat = 0; rline = '0;
    bus.dramra_ack = 0;
    bus.dramrd_rdy = 0;
    bus.i_dramrd   = '0;
    bus.dat_ack    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        have_req = 0; prev_ra = 0; prev_dat = 0;
        bus.dramra_ack = 0;
        bus.dramrd_rdy = 0;
        bus.dat_ack    = 0;
      end else begin
        if (hs_rd) bus.dramrd_rdy = 0;
        if (hs_ra) begin
          have_req = 1;
          rline    = last_req;
          rd_cnt   = rand_env ? int'($urandom_range(0, 4)) : rd_delay_cfg;
        end
        if (have_req) begin
          if (rd_cnt == 0) begin
            for (int k = 0; k < CSIZE; k++) bus.i_dramrd[k] = word_of(rline + 16'(k));
            bus.dramrd_rdy = 1;
            have_req = 0;
          end else begin
            rd_cnt--;
          end
        end
        if (bus.dramra_rdy && !prev_ra) ra_cnt = rand_env ? int'($urandom_range(0, 3)) : ra_stall_cfg;
        prev_ra = bus.dramra_rdy;
        if (bus.dramra_rdy && ra_cnt > 0) begin
          bus.dramra_ack = 0;
          ra_cnt--;
        end else begin
          bus.dramra_ack = 1;
        end
        if (bus.dat_rdy && !prev_dat) dat_cnt = rand_env ? int'($urandom_range(0, 3)) : dat_stall_cfg;
        prev_dat = bus.dat_rdy;
        if (bus.dat_rdy && dat_cnt > 0) begin
          bus.dat_ack = 0;
          dat_cnt--;
        end else begin
          bus.dat_ack = 1;
        end
      end
    end
  end

  function automatic logic [3:0][15:0] mkv(input logic [15:0] a0, a1, a2, a3);
    logic [3:0][15:0] v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    return v;
  endfunction

  task automatic send_vec(input logic [3:0][15:0] a, input logic [3:0] m, input bit wait_done);
    int n;
    req_log.delete();
    vec_done = 0;
    acc_evt  = 0;
    bus.i_address   = a;
    bus.i_valid     = m;
    bus.addrval_rdy = 1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_evt && n < 50);
    bus.addrval_rdy = 0;
    bus.i_address   = {$urandom, $urandom};
    bus.i_valid     = 4'($urandom);
    if (!acc_evt) check("accept_timeout", 64'd0, 64'd1);
    if (wait_done) begin
      n = 0;
      while (!vec_done && n < 400) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!vec_done) check("done_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addrval_ack"}, 64'(bus.addrval_ack), 64'd1);
    check({tag, "_dramra_rdy"}, 64'(bus.dramra_rdy), 64'd0);
    check({tag, "_dramrd_ack"}, 64'(bus.dramrd_ack), 64'd0);
    check({tag, "_dat_rdy"}, 64'(bus.dat_rdy), 64'd0);
    check({tag, "_o_dramra"}, 64'(bus.o_dramra), 64'd0);
    check({tag, "_o_dat"}, bus.o_dat, 64'd0);
    check({tag, "_o_valid"}, 64'(bus.o_valid), 64'd0);
  endtask

  initial begin : main
    int n;
    logic [63:0] t3_dat, t4_dat;
    bus.addrval_rdy = 0;
    bus.i_address   = '0;
    bus.i_valid     = '0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;

    // single line, zero-wait
    send_vec(mkv(16'h10, 16'h11, 16'h17, 16'h12), 4'b1111, 1);
    check("t1_nreq", 64'(req_log.size()), 64'd1);
    check("t1_req0", 64'(req_log[0]), 64'h10);
    check("t1_dat", last_dat, {16'h102, 16'h107, 16'h101, 16'h100});
    check("t1_valid", 64'(last_valid), 64'hF);
    check("t1_lat", 64'(last_lat), 64'd3);

    // two distinct lines with duplicate addresses
    send_vec(mkv(16'h20, 16'h08, 16'h21, 16'h08), 4'b1111, 1);
    check("t2_nreq", 64'(req_log.size()), 64'd2);
    check("t2_req0", 64'(req_log[0]), 64'h20);
    check("t2_req1", 64'(req_log[1]), 64'h08);
    check("t2_dat", last_dat, {16'h0F8, 16'h111, 16'h0F8, 16'h110});
    check("t2_lat", 64'(last_lat), 64'd5);

    // sparse mask: lanes 0 and 2 only
    send_vec(mkv(16'h30, 16'h40, 16'h50, 16'h60), 4'b0101, 1);
`ifdef DRAM_READ_SCATTER_ZERO_FILL_EN
    t3_dat = {16'h000, 16'h140, 16'h000, 16'h120};
    t4_dat = 64'd0;
`else
    t3_dat = {16'h0F8, 16'h140, 16'h0F8, 16'h120};
    t4_dat = t3_dat;
`endif
    check("t3_nreq", 64'(req_log.size()), 64'd2);
    check("t3_req0", 64'(req_log[0]), 64'h30);
    check("t3_req1", 64'(req_log[1]), 64'h50);
    check("t3_dat", last_dat, t3_dat);
    check("t3_valid", 64'(last_valid), 64'h5);

    // empty mask
    send_vec(mkv(16'h70, 16'h71, 16'h72, 16'h73), 4'b0000, 1);
    check("t4_nreq", 64'(req_log.size()), 64'd0);
    check("t4_lat", 64'(last_lat), 64'd1);
    check("t4_valid", 64'(last_valid), 64'h0);
    check("t4_dat", last_dat, t4_dat);

    // backpressure on every channel
    ra_stall_cfg = 5; rd_delay_cfg = 4; dat_stall_cfg = 3;
    send_vec(mkv(16'h10, 16'h11, 16'h17, 16'h12), 4'b1111, 1);
    check("t5_nreq", 64'(req_log.size()), 64'd1);
    check("t5_dat", last_dat, {16'h102, 16'h107, 16'h101, 16'h100});
    check("t5_lat", 64'(last_lat), 64'd12);

    // reset while waiting for DRAM data
    ra_stall_cfg = 0; rd_delay_cfg = 6; dat_stall_cfg = 0;
    send_vec(mkv(16'h20, 16'h08, 16'h21, 16'h08), 4'b1111, 0);
    n = 0;
    while (!bus.dramrd_ack && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_reach_wait", 64'(bus.dramrd_ack), 64'd1);
    #2 rst_n = 0;
    busy = 0; reqq.delete(); exp_dat = '0; exp_valid = '0;
    #1;
    check_reset("t6_midreset");
    @(posedge clk);
    #3 rst_n = 1;
    rd_delay_cfg = 0;
    @(posedge clk);
    #1;
    send_vec(mkv(16'h20, 16'h08, 16'h21, 16'h08), 4'b1111, 1);
    check("t6_nreq", 64'(req_log.size()), 64'd2);
    check("t6_dat", last_dat, {16'h0F8, 16'h111, 16'h0F8, 16'h110});
    check("t6_lat", 64'(last_lat), 64'd5);

    // random vectors: zero-wait first, then random stalls
    hash_mode = 1;
    for (int v = 0; v < 60; v++) begin
      rand_env = (v >= 20);
      send_vec(mkv(16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
                   16'($urandom_range(0, 63)), 16'($urandom_range(0, 63))),
               4'($urandom), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire
